// File: rtl/mem_bus_arbiter.sv
// Shares one downstream memory port between the fetch (ibus) and data (dbus) requesters.
// Define MEM_ARB_RR_EN for round-robin arbitration; otherwise dbus has fixed priority.
module mem_bus_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64,
    parameter int STRB_W = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              ireq_valid,
    input  logic [ADDR_W-1:0] ireq_addr,
    output logic              ireq_data_ok,
    output logic [DATA_W-1:0] ireq_rdata,

    input  logic              dreq_valid,
    input  logic [ADDR_W-1:0] dreq_addr,
    input  logic [2:0]        dreq_size,
    input  logic [STRB_W-1:0] dreq_strobe,
    input  logic [DATA_W-1:0] dreq_wdata,
    output logic              dreq_data_ok,
    output logic [DATA_W-1:0] dreq_rdata,

    output logic              oreq_valid,
    output logic              oreq_write,
    output logic [ADDR_W-1:0] oreq_addr,
    output logic [2:0]        oreq_size,
    output logic [STRB_W-1:0] oreq_strobe,
    output logic [DATA_W-1:0] oreq_wdata,
    input  logic              oresp_ok,
    input  logic [DATA_W-1:0] oresp_rdata
);

    typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
    typedef enum logic [1:0] {OWN_NONE, OWN_IBUS, OWN_DBUS} owner_t;

    localparam logic [2:0] MSIZE4 = 3'd2;

    state_t state;
    owner_t owner;
    logic   grant_dbus;

`ifdef MEM_ARB_RR_EN
    // Set when dbus won the previous grant; on contention the other side goes next.
    logic last_grant_dbus;
    assign grant_dbus = dreq_valid && (!ireq_valid || !last_grant_dbus);
`else
    assign grant_dbus = dreq_valid;
`endif

    // NOTE: every register here, including the wide latched request and rdata
    // registers, is cleared by the synchronous reset so all outputs read 0 after it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= IDLE;
            owner        <= OWN_NONE;
            oreq_valid   <= 1'b0;
            oreq_write   <= 1'b0;
            oreq_addr    <= '0;
            oreq_size    <= '0;
            oreq_strobe  <= '0;
            oreq_wdata   <= '0;
            ireq_data_ok <= 1'b0;
            ireq_rdata   <= '0;
            dreq_data_ok <= 1'b0;
            dreq_rdata   <= '0;
`ifdef MEM_ARB_RR_EN
            last_grant_dbus <= 1'b0;
`endif
        end else begin
            ireq_data_ok <= 1'b0;
            dreq_data_ok <= 1'b0;
            case (state)
                IDLE: begin
                    if (ireq_valid || dreq_valid) begin
                        state      <= BUSY;
                        oreq_valid <= 1'b1;
                        if (grant_dbus) begin
                            owner       <= OWN_DBUS;
                            oreq_write  <= |dreq_strobe;
                            oreq_addr   <= dreq_addr;
                            oreq_size   <= dreq_size;
                            oreq_strobe <= dreq_strobe;
                            oreq_wdata  <= dreq_wdata;
                        end else begin
                            owner       <= OWN_IBUS;
                            oreq_write  <= 1'b0;
                            oreq_addr   <= ireq_addr;
                            oreq_size   <= MSIZE4;
                            oreq_strobe <= '0;
                            oreq_wdata  <= '0;
                        end
`ifdef MEM_ARB_RR_EN
                        last_grant_dbus <= grant_dbus;
`endif
                    end
                end
                BUSY: begin
                    // Requester inputs are deliberately not looked at here: a granted
                    // transaction cannot be altered or aborted.
                    if (oresp_ok) begin
                        state      <= RESP;
                        oreq_valid <= 1'b0;
                        if (owner == OWN_DBUS) begin
                            dreq_rdata   <= oresp_rdata;
                            dreq_data_ok <= 1'b1;
                        end else begin
                            ireq_rdata   <= oresp_rdata;
                            ireq_data_ok <= 1'b1;
                        end
                    end
                end
                RESP: begin
                    state <= IDLE;
                    owner <= OWN_NONE;
                end
                default: begin
                    state      <= IDLE;
                    owner      <= OWN_NONE;
                    oreq_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: expected transactions are queued in grant
// order when requests are driven and compared as the downstream port and data_ok respond.
module tb_mem_bus_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;
    localparam int STRB_W = 8;

    typedef struct {
        bit              is_d;
        logic [63:0]     addr;
        logic [2:0]      size;
        logic [7:0]      strobe;
        logic [63:0]     wdata;
        logic [63:0]     rdata;
    } txn_t;

    logic              clk;
    logic              reset;
    logic              ireq_valid;
    logic [ADDR_W-1:0] ireq_addr;
    logic              ireq_data_ok;
    logic [DATA_W-1:0] ireq_rdata;
    logic              dreq_valid;
    logic [ADDR_W-1:0] dreq_addr;
    logic [2:0]        dreq_size;
    logic [STRB_W-1:0] dreq_strobe;
    logic [DATA_W-1:0] dreq_wdata;
    logic              dreq_data_ok;
    logic [DATA_W-1:0] dreq_rdata;
    logic              oreq_valid;
    logic              oreq_write;
    logic [ADDR_W-1:0] oreq_addr;
    logic [2:0]        oreq_size;
    logic [STRB_W-1:0] oreq_strobe;
    logic [DATA_W-1:0] oreq_wdata;
    logic              oresp_ok;
    logic [DATA_W-1:0] oresp_rdata;

    int   checks = 0;
    int   errors = 0;
    txn_t exp_q[$];
    logic [63:0] exp_irdata = '0;
    logic [63:0] exp_drdata = '0;

    mem_bus_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .STRB_W(STRB_W)) dut (
        .clk(clk), .reset(reset),
        .ireq_valid(ireq_valid), .ireq_addr(ireq_addr),
        .ireq_data_ok(ireq_data_ok), .ireq_rdata(ireq_rdata),
        .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
        .dreq_strobe(dreq_strobe), .dreq_wdata(dreq_wdata),
        .dreq_data_ok(dreq_data_ok), .dreq_rdata(dreq_rdata),
        .oreq_valid(oreq_valid), .oreq_write(oreq_write), .oreq_addr(oreq_addr),
        .oreq_size(oreq_size), .oreq_strobe(oreq_strobe), .oreq_wdata(oreq_wdata),
        .oresp_ok(oresp_ok), .oresp_rdata(oresp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic txn_t mk_i(input logic [63:0] addr, input logic [63:0] rdata);
        txn_t t;
        t.is_d = 1'b0; t.addr = addr; t.size = 3'd2; t.strobe = '0; t.wdata = '0; t.rdata = rdata;
        return t;
    endfunction

    function automatic txn_t mk_d(input logic [63:0] addr, input logic [2:0] size,
                                  input logic [7:0] strobe, input logic [63:0] wdata,
                                  input logic [63:0] rdata);
        txn_t t;
        t.is_d = 1'b1; t.addr = addr; t.size = size; t.strobe = strobe; t.wdata = wdata; t.rdata = rdata;
        return t;
    endfunction

    task automatic apply(input txn_t t);
        if (t.is_d) begin
            dreq_valid = 1'b1; dreq_addr = t.addr; dreq_size = t.size;
            dreq_strobe = t.strobe; dreq_wdata = t.wdata;
        end else begin
            ireq_valid = 1'b1; ireq_addr = t.addr;
        end
    endtask

    // Memory side: wait for the grant, compare the latched request against the queue
    // head, hold for 'delay' cycles, respond, and check the one-cycle data_ok pulse.
    // Called and returns at a negedge; returns in the IDLE cycle after RESP.
    task automatic serve_one(input int delay);
        txn_t t;
        int   n;
        logic exp_w;
        n = 0;
        while (oreq_valid !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (oreq_valid !== 1'b1 || exp_q.size() == 0) begin
            errors++;
            $display("FAIL grant_wait: oreq_valid=%b pending=%0d (expected 1 and >0)", oreq_valid, exp_q.size());
            return;
        end
        t = exp_q.pop_front();
        exp_w = |t.strobe;
        checks++;
        if ({oreq_write, oreq_addr, oreq_size, oreq_strobe, oreq_wdata} !==
            {exp_w, t.addr, t.size, t.strobe, t.wdata}) begin
            errors++;
            $display("FAIL latch_%s: got w=%b a=%h sz=%0d st=%h wd=%h exp w=%b a=%h sz=%0d st=%h wd=%h",
                     t.is_d ? "dbus" : "ibus", oreq_write, oreq_addr, oreq_size, oreq_strobe, oreq_wdata,
                     exp_w, t.addr, t.size, t.strobe, t.wdata);
        end
        for (int i = 0; i < delay; i++) begin
            @(negedge clk);
            checks++;
            if ({oreq_valid, oreq_write, oreq_addr, oreq_size, oreq_strobe, oreq_wdata, ireq_data_ok, dreq_data_ok} !==
                {1'b1, exp_w, t.addr, t.size, t.strobe, t.wdata, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL busy_hold: cycle %0d got v=%b a=%h wd=%h ok=%b%b exp v=1 a=%h wd=%h ok=00",
                         i, oreq_valid, oreq_addr, oreq_wdata, ireq_data_ok, dreq_data_ok, t.addr, t.wdata);
            end
        end
        oresp_ok = 1'b1;
        oresp_rdata = t.rdata;
        @(negedge clk);
        oresp_ok = 1'b0;
        oresp_rdata = '0;
        if (t.is_d) exp_drdata = t.rdata;
        else exp_irdata = t.rdata;
        checks++;
        if ({ireq_data_ok, dreq_data_ok, oreq_valid} !== {!t.is_d, t.is_d, 1'b0} ||
            ireq_rdata !== exp_irdata || dreq_rdata !== exp_drdata) begin
            errors++;
            $display("FAIL resp_%s: got iok=%b dok=%b v=%b ird=%h drd=%h exp iok=%b dok=%b v=0 ird=%h drd=%h",
                     t.is_d ? "dbus" : "ibus", ireq_data_ok, dreq_data_ok, oreq_valid, ireq_rdata, dreq_rdata,
                     !t.is_d, t.is_d, exp_irdata, exp_drdata);
        end
        if (t.is_d) dreq_valid = 1'b0;
        else ireq_valid = 1'b0;
        @(negedge clk);
        checks++;
        if (ireq_data_ok !== 1'b0 || dreq_data_ok !== 1'b0) begin
            errors++;
            $display("FAIL pulse_width: got iok=%b dok=%b exp 0 0", ireq_data_ok, dreq_data_ok);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        ireq_valid = 0; ireq_addr = '0;
        dreq_valid = 0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_wdata = '0;
        oresp_ok = 0; oresp_rdata = '0;
        repeat (2) @(negedge clk);
        checks++;
        if ({ireq_data_ok, ireq_rdata, dreq_data_ok, dreq_rdata, oreq_valid, oreq_write,
             oreq_addr, oreq_size, oreq_strobe, oreq_wdata} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got v=%b a=%h ird=%h drd=%h exp all zero",
                     oreq_valid, oreq_addr, ireq_rdata, dreq_rdata);
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single_fetch();
        txn_t t;
        t = mk_i(64'h0000_0000_8000_0000, 64'h0000_0013_0000_0093);
        exp_q.push_back(t);
        apply(t);
        @(negedge clk);
        checks++;
        if (oreq_valid !== 1'b1) begin
            errors++;
            $display("FAIL fetch_latency: oreq_valid=%b one cycle after valid, exp 1", oreq_valid);
        end
        serve_one(0);
    endtask

    task automatic test_store();
        txn_t t;
        t = mk_d(64'h0000_0000_8000_1004, 3'd2, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h1111_2222_3333_4444);
        exp_q.push_back(t);
        apply(t);
        serve_one(1);
    endtask

    task automatic test_simultaneous();
        txn_t ti, td;
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        exp_irdata = '0; exp_drdata = '0;
        for (int r = 0; r < 2; r++) begin
            ti = mk_i(64'h8000_0100 + 64'(r * 16), 64'hA0A0_0000_0000_0000 + 64'(r));
            td = mk_d(64'h8000_2000 + 64'(r * 8), 3'd3, 8'h00, 64'h0, 64'hD0D0_0000_0000_0000 + 64'(r));
            exp_q.push_back(td);
            exp_q.push_back(ti);
            apply(ti);
            apply(td);
            serve_one(r);
            serve_one(1);
        end
    endtask

    task automatic test_starvation();
        txn_t ti, ta, tb;
        ti = mk_i(64'h8000_0300, 64'h1234_5678_9ABC_DEF0);
        ta = mk_d(64'h8000_3000, 3'd0, 8'h01, 64'h55, 64'h0F0F_0F0F_0F0F_0F0F);
        tb = mk_d(64'h8000_3008, 3'd1, 8'h0C, 64'h0000_0000_BEEF_0000, 64'hF0F0_F0F0_F0F0_F0F0);
        exp_q.push_back(ta);
        exp_q.push_back(ti);
        apply(ti);
        apply(ta);
        serve_one(0);
        apply(tb);
`ifdef MEM_ARB_RR_EN
        exp_q.push_back(tb);
`else
        exp_q.push_front(tb);
`endif
        serve_one(0);
        serve_one(0);
    endtask

    task automatic test_input_stability();
        txn_t t;
        t = mk_i(64'h8000_0400, 64'hCAFE_F00D_0000_0001);
        exp_q.push_back(t);
        apply(t);
        @(negedge clk);
        ireq_addr = 64'hFFFF_0000_1111_2222;
        dreq_addr = 64'h3333_4444_5555_6666;
        dreq_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        ireq_valid = 1'b0;
        serve_one(5);
    endtask

    task automatic test_reset_mid();
        txn_t t;
        t = mk_i(64'h8000_0500, 64'h0);
        apply(t);
        @(negedge clk);
        reset = 1'b1;
        ireq_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({oreq_valid, ireq_data_ok, dreq_data_ok, ireq_rdata, dreq_rdata, oreq_addr} !== '0) begin
            errors++;
            $display("FAIL reset_mid: got v=%b ok=%b%b ird=%h drd=%h a=%h exp all zero",
                     oreq_valid, ireq_data_ok, dreq_data_ok, ireq_rdata, dreq_rdata, oreq_addr);
        end
        reset = 1'b0;
        exp_q.delete();
        exp_irdata = '0; exp_drdata = '0;
        @(negedge clk);
        t = mk_i(64'h8000_0600, 64'h7777_8888_9999_AAAA);
        exp_q.push_back(t);
        apply(t);
        serve_one(2);
    endtask

    task automatic test_stray_response();
        oresp_ok = 1'b1;
        oresp_rdata = 64'hBAD0_BAD0_BAD0_BAD0;
        @(negedge clk);
        oresp_ok = 1'b0;
        oresp_rdata = '0;
        checks++;
        if ({ireq_data_ok, dreq_data_ok, oreq_valid} !== 3'b000 ||
            ireq_rdata !== exp_irdata || dreq_rdata !== exp_drdata) begin
            errors++;
            $display("FAIL stray_resp: got ok=%b%b v=%b ird=%h drd=%h exp ok=00 v=0 ird=%h drd=%h",
                     ireq_data_ok, dreq_data_ok, oreq_valid, ireq_rdata, dreq_rdata, exp_irdata, exp_drdata);
        end
        @(negedge clk);
        checks++;
        if ({ireq_data_ok, dreq_data_ok, oreq_valid} !== 3'b000) begin
            errors++;
            $display("FAIL stray_state: got ok=%b%b v=%b exp 000", ireq_data_ok, dreq_data_ok, oreq_valid);
        end
        exp_q.push_back(mk_i(64'h8000_0700, 64'h0101_0202_0303_0404));
        apply(exp_q[0]);
        serve_one(0);
    endtask

    initial begin
        test_reset();
        test_single_fetch();
        test_store();
        test_simultaneous();
        test_starvation();
        test_input_stability();
        test_reset_mid();
        test_stray_response();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d transactions left, exp 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
